video_shifter: RTL

VIDEO_SHIFTER -- requirements
Module: video_shifter

---
 rtl/video_pkg.sv | 23 ++
 rtl/video_shifter_if.sv | 47 ++++
 rtl/video_delay_pipe.sv | 48 ++++
 rtl/video_shifter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared constants and the shifter state type for the
//                monochrome video pixel shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  // Pixels per video RAM word.
  localparam int VIDEO_WORD_BITS   = 16;
  // Clock stages between the timer's sync/blank outputs and the pins.
  localparam int VIDEO_ALIGN_DEPTH = 2;
  // Width of the bits-left counter; must hold 0..VIDEO_WORD_BITS.
  localparam int VIDEO_CNT_BITS    = 5;

  typedef enum logic {
    EMPTY    = 1'b0,
    SHIFTING = 1'b1
  } shift_state_e;

endpackage : video_pkg
`default_nettype wire

// File: rtl/video_shifter_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_shifter_if
//  Description : Timer-to-shifter bus: bus-rate enable, word fetch strobe,
//                video word, raw timing in, aligned pixel/timing out.
//                The underrun flag exists only when VIDEO_UNDERRUN_DET_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_shifter_if;
  import video_pkg::*;

  logic                       clk_en;
  logic                       loadPixels;
  logic [VIDEO_WORD_BITS-1:0] dataIn;
  logic                       hsync_in;
  logic                       vsync_in;
  logic                       _hblank_in;
  logic                       _vblank_in;
  logic                       pixel;
  logic                       hsync;
  logic                       vsync;
  logic                       de;
`ifdef VIDEO_UNDERRUN_DET_EN
  logic                       underrun;
`endif

  // Video timer side.
  modport master (
    output clk_en, loadPixels, dataIn, hsync_in, vsync_in, _hblank_in, _vblank_in,
`ifdef VIDEO_UNDERRUN_DET_EN
    input  underrun,
`endif
    input  pixel, hsync, vsync, de
  );

  // Shifter side.
  modport slave (
    input  clk_en, loadPixels, dataIn, hsync_in, vsync_in, _hblank_in, _vblank_in,
`ifdef VIDEO_UNDERRUN_DET_EN
    output underrun,
`endif
    output pixel, hsync, vsync, de
  );

endinterface : video_shifter_if
`default_nettype wire

// File: rtl/video_delay_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : video_delay_pipe
//  Description : Parameterised-depth, parameterised-width delay line. The
//                first stage loads only when en=1; later stages advance
//                every clock. Reset loads RST_VAL into every stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_delay_pipe #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Next-stage values: enabled load at the head, free-running behind it.
  always_comb begin
    stage_d[0] = en ? din : stage_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule : video_delay_pipe
`default_nettype wire

// File: rtl/video_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : video_shifter
//  Description : 16-bit video word shifter with a one-word holding register
//                for seamless back-to-back words, inverted (Mac polarity)
//                registered pixel output, and sync/de alignment delay.
//                Optional sticky underrun detector: VIDEO_UNDERRUN_DET_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_shifter
  import video_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  video_shifter_if.slave vif
);

  localparam logic [VIDEO_CNT_BITS-1:0] WORD_CNT = VIDEO_CNT_BITS'(VIDEO_WORD_BITS);

  logic [VIDEO_WORD_BITS-1:0] hold_q, hold_d;
  logic                       hold_valid_q, hold_valid_d;
  logic [VIDEO_WORD_BITS-1:0] sr_q, sr_d;
  logic [VIDEO_CNT_BITS-1:0]  bits_left_q, bits_left_d;
  logic                       pixel_q, pixel_d;

  shift_state_e state;
  logic         capture;
  logic         transfer;
  logic [2:0]   tim_raw;
  logic [2:0]   tim_pre;
  logic [2:0]   tim_out;
  logic         de_next;

  // Timing bundle {hsync, vsync, de}; syncs idle high, de idles low.
  assign tim_raw = {vif.hsync_in, vif.vsync_in, vif._hblank_in & vif._vblank_in};

  // Bus-rate resample plus all but the last alignment stage.
  video_delay_pipe #(
    .DEPTH   (VIDEO_ALIGN_DEPTH - 1),
    .WIDTH   (3),
    .RST_VAL (3'b110)
  ) u_align_pre (
    .clk   (clk),
    .reset (reset),
    .en    (vif.clk_en),
    .din   (tim_raw),
    .dout  (tim_pre)
  );

  // Final alignment stage; its input is the de that will sit beside the
  // pixel being computed this cycle.
  video_delay_pipe #(
    .DEPTH   (1),
    .WIDTH   (3),
    .RST_VAL (3'b110)
  ) u_align_out (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .din   (tim_pre),
    .dout  (tim_out)
  );

  assign de_next   = tim_pre[0];
  assign vif.hsync = tim_out[2];
  assign vif.vsync = tim_out[1];
  assign vif.de    = tim_out[0];
  assign vif.pixel = pixel_q;

  assign capture  = vif.clk_en & vif.loadPixels;
  // Reload on the last bit too, so the next word follows with no gap.
  assign transfer = hold_valid_q && (bits_left_q <= VIDEO_CNT_BITS'(1));

  // Shifter state is implied by the bits-left counter.
  always_comb begin
    state = (bits_left_q == '0) ? EMPTY : SHIFTING;
  end

  // Next-state logic for holding register, shift register, counter and pixel.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    sr_d         = sr_q;
    bits_left_d  = bits_left_q;
    pixel_d      = 1'b0;

    if (transfer) begin
      sr_d         = hold_q;
      bits_left_d  = WORD_CNT;
      hold_valid_d = 1'b0;
    end else begin
      unique case (state)
        SHIFTING: begin
          sr_d        = {sr_q[VIDEO_WORD_BITS-2:0], 1'b0};
          bits_left_d = bits_left_q - VIDEO_CNT_BITS'(1);
        end
        default: begin
          sr_d        = sr_q;
          bits_left_d = bits_left_q;
        end
      endcase
    end

    // A capture after the transfer term lets the new word land in hold
    // while the old one moves to sr; newest capture always wins.
    if (capture) begin
      hold_d       = vif.dataIn;
      hold_valid_d = 1'b1;
    end

    if ((state == SHIFTING) && de_next) begin
      pixel_d = ~sr_q[VIDEO_WORD_BITS-1];
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      sr_q         <= '0;
      bits_left_q  <= '0;
      pixel_q      <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      sr_q         <= sr_d;
      bits_left_q  <= bits_left_d;
      pixel_q      <= pixel_d;
    end
  end

`ifdef VIDEO_UNDERRUN_DET_EN
  logic underrun_q, underrun_d;

  // Sticky: display active with nothing shifting and nothing queued.
  always_comb begin
    underrun_d = underrun_q | (de_next & (state == EMPTY) & ~hold_valid_q);
  end

  // Underrun flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign vif.underrun = underrun_q;
`endif

endmodule : video_shifter
`default_nettype wire
